r5p_test_ctrl: RTL
==================

// Module: r5p_test_ctrl
//
// PURPOSE
//  Synthesizable RISC-V compliance test controller and TCB subordinate.
//  Sits on the controller port (0x20_0000..0x2f_ffff) of the system-bus demultiplexer, downstream of the core.
//  Captures the signature bounds (begin/end) and the halt request written by the test.
//  Buffers console bytes in a small FIFO.
//  Flags timeout so the bench or an FPGA host can end the run and dump the signature.
//
// PARAMETERS
//  DW     32   data width (bytes = DW/8); register file is DW-wide
//  AW     5    decoded address width (byte address, word aligned)
//  TMO    0    timeout in clock cycles after reset; 0 disables timeout
//  FDP    4    console FIFO depth, power of 2, >= 2
//
// PORTS
//  clk      input   1       clock
//  rst      input   1       reset; asynchronous assert, active-low
//  bus_vld  input   1       TCB request valid
//  bus_wen  input   1       TCB write enable
//  bus_adr  input   AW      TCB byte address
//  bus_ben  input   DW/8    TCB byte enables
//  bus_wdt  input   DW      TCB write data
//  bus_rdt  output  DW      TCB read data (response phase)
//  bus_err  output  1       TCB error (response phase)
//  bus_rdy  output  1       TCB ready; transfer trn = bus_vld & bus_rdy
//  sig_beg  output  DW      signature begin address
//  sig_end  output  DW      signature end address
//  halt     output  1       test requested halt (sticky)
//  timeout  output  1       timeout expired (sticky)
//  con_vld  output  1       console byte valid
//  con_dat  output  8       console byte
//  con_rdy  input   1       console consumer ready; pop = con_vld & con_rdy
//
// BEHAVIOUR
//  Reset (rst=0, async): sig_beg=0, sig_end=0, halt=0, timeout=0, bus_rdt=0, bus_err=0, con_vld=0, FIFO empty, counters 0.
//  Register map (offset = bus_adr):
//   0x00 SIG_BEG RW
//   0x08 SIG_END RW
//   0x10 HALT W: wdt[0]=1 sets halt; R: {..,timeout,halt}
//   0x0C CON W: byte wdt[7:0] pushed to FIFO (ben[0] required, else no push); R: 0
//   0x14 STATUS RO: [0]halt [1]timeout [15:8]FIFO level
//  Writes to RW regs honour bus_ben per byte. Writes to RO offsets are ignored, err=0.
//  Response latency 1 (DLY=1): bus_rdt/bus_err registered on the trn cycle, valid the next cycle, held until the next trn.
//  Any other offset: no state change, bus_err=1 in the response.
//  bus_rdy = 1, except for a write to CON while the FIFO is full: then bus_rdy=0 until a pop frees an entry.
//   bus_rdy for a CON write = !full, evaluated combinationally from registered state.
//  FIFO:
//   - Pointers carry an extra wrap bit; full = (wr^rd)==FDP, empty = wr==rd.
//   - Push and pop in the same cycle: when full, only the pop happens (push stalled by rdy); otherwise both happen and the level is unchanged.
//   - No bypass: a byte pushed into an empty FIFO appears on con_vld the next cycle.
//  halt and timeout are sticky until reset.
//  Timeout counter:
//   - Counts every cycle while !halt & !timeout & TMO!=0.
//   - Sets timeout when count == TMO-1, then freezes.
//   - halt and timeout both rising in the same cycle: both set.
//  Reset mid-transfer: all state cleared immediately; any pending response is dropped.
//
// CONFIGURATION
//  R5P_TEST_CTRL_CYCLE_EN defined:
//   - 64-bit free-running cycle counter (from reset, counts through halt).
//   - Readable at 0x18 (low word) and 0x1C (high word).
//   - Reading 0x18 snapshots the high word; a subsequent 0x1C read returns the snapshot.
//  Not defined: no counter logic; 0x18/0x1C are unmapped (bus_err=1).
//
// STRUCTURE
//  r5p_test_ctrl_pkg holds:
//   - register offset localparams (SIG_BEG, SIG_END, CON, HALT, STATUS, CYC_LO, CYC_HI)
//   - STATUS bit-position constants
//   - status_t packed struct
//  Sub-module r5p_test_ctrl_fifo: parameterized synchronous FIFO (DW=8, FDP), push/pop/full/empty/level ports.
//
// TESTING
//  - Reset release, read 0x00/0x08/0x14 -> rdt=0 each, err=0, one cycle after trn; halt=timeout=0.
//  - Write 0x00=0x0000_1000 ben=4'b0011, then 0x08=0x0000_2000 ben=4'hf -> sig_beg=0x0000_1000, sig_end=0x0000_2000.
//  - Write 0x10 wdt=1 -> halt=1 next cycle; a later write 0x10 wdt=0 keeps halt=1; timeout counter frozen.
//  - Five CON writes 'A'..'E', FDP=4, con_rdy=0 -> 4 accepted, 5th stalls rdy=0; con_rdy=1 pops 'A' and releases 'E'; output order A..E.
//  - TMO=100, no halt -> timeout=1 exactly 100 cycles after reset release; read 0x14 -> bit1=1.
//  - Read 0x04 -> err=1, no state change.
//    With R5P_TEST_CTRL_CYCLE_EN: read 0x18 then 0x1C -> monotonic 64-bit value.
//    Without: 0x18 -> err=1.

Source files
------------

// File: rtl/r5p_test_ctrl_pkg.sv
// Package for the RISC-V compliance test controller.
// Holds the register map offsets, STATUS bit positions, the STATUS
// layout struct and a helper that assembles a STATUS word.
package r5p_test_ctrl_pkg;

    // Register offsets (byte address, word aligned).
    localparam int unsigned SIG_BEG = 32'h00;
    localparam int unsigned SIG_END = 32'h08;
    localparam int unsigned CON     = 32'h0C;
    localparam int unsigned HALT    = 32'h10;
    localparam int unsigned STATUS  = 32'h14;
    localparam int unsigned CYC_LO  = 32'h18;
    localparam int unsigned CYC_HI  = 32'h1C;

    // STATUS / HALT read-back bit positions.
    localparam int unsigned STS_HALT_BIT = 32'd0;
    localparam int unsigned STS_TMO_BIT  = 32'd1;
    localparam int unsigned STS_LVL_LSB  = 32'd8;

    typedef struct packed {
        logic [7:0] level;
        logic [5:0] rsv;
        logic       timeout;
        logic       halt;
    } status_t;

    // Assemble a STATUS word from its fields.
    function automatic status_t pack_status(input logic       halt_i,
                                            input logic       timeout_i,
                                            input logic [7:0] level_i);
        logic [15:0] v;
        v = 16'h0000;
        v[STS_HALT_BIT]       = halt_i;
        v[STS_TMO_BIT]        = timeout_i;
        v[STS_LVL_LSB +: 8]   = level_i;
        return status_t'(v);
    endfunction

endpackage

// File: rtl/r5p_test_ctrl_fifo.sv
// Synchronous FIFO used as the console byte buffer.
// Ports: push_i/din_i write side, pop_i/dout_o read side, full_o, empty_o,
// level_o (number of stored entries). Pointers carry an extra wrap bit.
// A push while full and a pop while empty are ignored. No bypass path:
// a byte pushed into an empty FIFO becomes visible the following cycle.
module r5p_test_ctrl_fifo #(
    parameter int unsigned DW  = 8,
    parameter int unsigned FDP = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DW-1:0]          din_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(FDP):0]   level_o
);
    localparam int unsigned PW = $clog2(FDP);

    logic [DW-1:0] mem_q [FDP];
    logic [PW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          do_push_s, do_pop_s;

    // Pointers differing only in the wrap bit means every slot is used.
    assign full_o  = ((wr_q ^ rd_q) == (PW+1)'(FDP));
    assign empty_o = (wr_q == rd_q);
    assign level_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[PW-1:0]];

    // Next-state pointers from qualified push/pop.
    always_comb begin
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
        wr_d      = wr_q;
        rd_d      = rd_q;
        if (do_push_s) begin
            wr_d = wr_q + (PW+1)'(1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + (PW+1)'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FDP; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push_s) begin
                mem_q[wr_q[PW-1:0]] <= din_i;
            end
        end
    end

endmodule

// File: rtl/r5p_test_ctrl.sv
// RISC-V compliance test controller, TCB subordinate with response latency 1.
// Captures signature bounds and the halt request, buffers console bytes,
// and flags a timeout TMO cycles after reset (TMO=0 disables it).
// Ports: clk, rst (async, active-low); TCB bus_vld/wen/adr/ben/wdt in,
// bus_rdt/err (response phase) and bus_rdy out; sig_beg, sig_end, halt,
// timeout status outputs; console stream con_vld/con_dat out, con_rdy in.
// Optional feature macro R5P_TEST_CTRL_CYCLE_EN: 64-bit cycle counter
// readable at CYC_LO/CYC_HI; without it those offsets respond with error.
module r5p_test_ctrl
    import r5p_test_ctrl_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 5,
    parameter int unsigned TMO = 0,
    parameter int unsigned FDP = 4
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            bus_vld,
    input  logic            bus_wen,
    input  logic [AW-1:0]   bus_adr,
    input  logic [DW/8-1:0] bus_ben,
    input  logic [DW-1:0]   bus_wdt,
    output logic [DW-1:0]   bus_rdt,
    output logic            bus_err,
    output logic            bus_rdy,
    output logic [DW-1:0]   sig_beg,
    output logic [DW-1:0]   sig_end,
    output logic            halt,
    output logic            timeout,
    output logic            con_vld,
    output logic [7:0]      con_dat,
    input  logic            con_rdy
);
    localparam int unsigned BW = DW/8;
    localparam int unsigned LW = $clog2(FDP) + 1;
    localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [DW-1:0] sig_beg_q, sig_beg_d, sig_end_q, sig_end_d;
    logic [DW-1:0] rdt_q, rdt_d, rd_s, wmask_s;
    logic          err_q, err_d, hit_s;
    logic          halt_q, halt_d, timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trn_s, wr_s, con_sel_s, push_s, pop_s, full_s, empty_s;
    logic [LW-1:0] level_s;

`ifdef R5P_TEST_CTRL_CYCLE_EN
    logic [63:0]   cyc_q;
    logic [DW-1:0] cyc_hi_q, cyc_hi_d;
`endif

    // A CON write is held off only while the FIFO is full.
    assign con_sel_s = (bus_adr == AW'(CON));
    assign bus_rdy   = ~(bus_vld & bus_wen & con_sel_s & full_s);
    assign trn_s     = bus_vld & bus_rdy;
    assign wr_s      = trn_s & bus_wen;
    assign pop_s     = con_vld & con_rdy;
    assign con_vld   = ~empty_s;

    assign bus_rdt = rdt_q;
    assign bus_err = err_q;
    assign sig_beg = sig_beg_q;
    assign sig_end = sig_end_q;
    assign halt    = halt_q;
    assign timeout = timeout_q;

    r5p_test_ctrl_fifo #(
        .DW  (8),
        .FDP (FDP)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .din_i   (bus_wdt[7:0]),
        .pop_i   (pop_s),
        .dout_o  (con_dat),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level_s)
    );

    // Expand byte enables into a per-bit write mask.
    always_comb begin
        wmask_s = '0;
        for (int b = 0; b < BW; b++) begin
            wmask_s[8*b +: 8] = {8{bus_ben[b]}};
        end
    end

    // Address decode, register writes and response capture.
    always_comb begin
        sig_beg_d = sig_beg_q;
        sig_end_d = sig_end_q;
        halt_d    = halt_q;
        rdt_d     = rdt_q;
        err_d     = err_q;
        rd_s      = '0;
        hit_s     = 1'b1;
        push_s    = 1'b0;
`ifdef R5P_TEST_CTRL_CYCLE_EN
        cyc_hi_d  = cyc_hi_q;
`endif
        case (bus_adr)
            AW'(SIG_BEG): begin
                rd_s = sig_beg_q;
                if (wr_s) begin
                    sig_beg_d = (sig_beg_q & ~wmask_s) | (bus_wdt & wmask_s);
                end else begin
                    sig_beg_d = sig_beg_q;
                end
            end
            AW'(SIG_END): begin
                rd_s = sig_end_q;
                if (wr_s) begin
                    sig_end_d = (sig_end_q & ~wmask_s) | (bus_wdt & wmask_s);
                end else begin
                    sig_end_d = sig_end_q;
                end
            end
            AW'(CON): begin
                rd_s   = '0;
                push_s = wr_s & bus_ben[0];
            end
            AW'(HALT): begin
                rd_s = DW'({timeout_q, halt_q});
                if (wr_s && bus_wdt[0]) begin
                    halt_d = 1'b1;
                end else begin
                    halt_d = halt_q;
                end
            end
            AW'(STATUS): begin
                rd_s = DW'(pack_status(halt_q, timeout_q, 8'(level_s)));
            end
`ifdef R5P_TEST_CTRL_CYCLE_EN
            AW'(CYC_LO): begin
                rd_s = DW'(cyc_q);
                // Freeze the high word so a following CYC_HI read is coherent.
                if (trn_s && !bus_wen) begin
                    cyc_hi_d = DW'(cyc_q >> 32);
                end else begin
                    cyc_hi_d = cyc_hi_q;
                end
            end
            AW'(CYC_HI): begin
                rd_s = cyc_hi_q;
            end
`else
            AW'(CYC_LO), AW'(CYC_HI): begin
                hit_s = 1'b0;
            end
`endif
            default: begin
                hit_s = 1'b0;
            end
        endcase
        if (trn_s) begin
            rdt_d = bus_wen ? '0 : rd_s;
            err_d = ~hit_s;
        end else begin
            rdt_d = rdt_q;
            err_d = err_q;
        end
    end

    // Timeout counter; stops once halted or expired.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if ((TMO != 0) && !halt_q && !timeout_q) begin
            if (cnt_q == CW'(TMO - 1)) begin
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Configuration registers, sticky flags and bus response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_beg_q <= '0;
            sig_end_q <= '0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            rdt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            sig_beg_q <= sig_beg_d;
            sig_end_q <= sig_end_d;
            halt_q    <= halt_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            rdt_q     <= rdt_d;
            err_q     <= err_d;
        end
    end

`ifdef R5P_TEST_CTRL_CYCLE_EN
    // Free-running cycle counter and high-word snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q    <= 64'd0;
            cyc_hi_q <= '0;
        end else begin
            cyc_q    <= cyc_q + 64'd1;
            cyc_hi_q <= cyc_hi_d;
        end
    end
`endif

endmodule
